// File: rtl/fpalu_pkg.sv
// Shared FP32 field layout, constants and sequencer states for the FP ALU blocks.
package fpalu_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int SIG_W  = MANT_W + 1;

    localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
    localparam logic [EXP_W-1:0] EXP_MAX  = 8'd255;
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_DONE
    } fpsub_state_t;

endpackage

// File: rtl/fpalu_unpack.sv
// Combinational FP32 unpack: field split, denormal flush, hidden bit, inf/NaN flags.
module fpalu_unpack
    import fpalu_pkg::*;
(
    input  logic [31:0]       i_fp,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [SIG_W-1:0]  o_sig,
    output logic              o_inf,
    output logic              o_nan
);

    logic [MANT_W-1:0] w_mant;
    logic              w_exp_zero;
    logic              w_exp_max;

    assign o_sign     = i_fp[EXP_W+MANT_W +: SIGN_W];
    assign o_exp      = i_fp[MANT_W +: EXP_W];
    assign w_mant     = i_fp[MANT_W-1:0];
    assign w_exp_zero = (o_exp == '0);
    assign w_exp_max  = (o_exp == EXP_MAX);

    // Denormals carry exp 0 and a zero significand, i.e. they behave as zero.
    assign o_sig = w_exp_zero ? '0 : {1'b1, w_mant};
    assign o_inf = w_exp_max && (w_mant == '0);
    assign o_nan = w_exp_max && (w_mant != '0);

endmodule

// File: rtl/fpalu_sub.sv
// Serial FP32 subtractor: diff = a_input - b_input, one-bit-per-cycle align and normalize.
module fpalu_sub
    import fpalu_pkg::*;
#(
    parameter int ALIGN_CAP = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_input,
    input  logic [31:0] b_input,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] diff
);

    // Significands carry guard, round and sticky bits below the 24-bit integer part.
    localparam int XW = SIG_W + 3;
    localparam logic [EXP_W-1:0] CAP8 = EXP_W'(ALIGN_CAP);

    function automatic logic [XW:0] shr_sticky(input logic [XW:0] v);
        return {1'b0, v[XW:2], v[1] | v[0]};
    endfunction

    function automatic logic [31:0] trunc_pack(input logic s, input logic [EXP_W-1:0] e,
                                               input logic [XW:0] v);
        if (e == EXP_MAX)
            return {s, EXP_MAX, {MANT_W{1'b0}}};
        return {s, e, v[XW-2:3]};
    endfunction

    fpsub_state_t r_state, w_next;

    logic              w_a_sign, w_b_sign, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [EXP_W-1:0]  w_a_exp, w_b_exp, w_p_exp, w_s_exp, w_d, w_cnt;
    logic [SIG_W-1:0]  w_a_sig, w_b_sig, w_p_sig, w_s_sig;
    logic              w_a_ge, w_b_esign, w_eff_sub, w_res_sign, w_special, w_capped;
    logic [31:0]       w_spec_val;

    logic              r_sign, r_eff_sub, r_special, r_capped;
    logic [EXP_W-1:0]  r_cnt, r_exp;
    logic [XW-1:0]     r_p, r_s;
    logic [XW:0]       r_sum;
    logic [31:0]       r_spec_val, r_diff;

    fpalu_unpack u_unpack_a (
        .i_fp   (a_input),
        .o_sign (w_a_sign),
        .o_exp  (w_a_exp),
        .o_sig  (w_a_sig),
        .o_inf  (w_a_inf),
        .o_nan  (w_a_nan)
    );

    fpalu_unpack u_unpack_b (
        .i_fp   (b_input),
        .o_sign (w_b_sign),
        .o_exp  (w_b_exp),
        .o_sig  (w_b_sig),
        .o_inf  (w_b_inf),
        .o_nan  (w_b_nan)
    );

    // Operand ordering: larger magnitude becomes primary, ties keep a as primary.
    assign w_a_ge     = {w_a_exp, w_a_sig[MANT_W-1:0]} >= {w_b_exp, w_b_sig[MANT_W-1:0]};
    assign w_b_esign  = ~w_b_sign;
    assign w_eff_sub  = w_a_sign ^ w_b_esign;
    assign w_res_sign = w_a_ge ? w_a_sign : w_b_esign;
    assign w_p_exp    = w_a_ge ? w_a_exp : w_b_exp;
    assign w_s_exp    = w_a_ge ? w_b_exp : w_a_exp;
    assign w_p_sig    = w_a_ge ? w_a_sig : w_b_sig;
    assign w_s_sig    = w_a_ge ? w_b_sig : w_a_sig;
    assign w_d        = w_p_exp - w_s_exp;
    assign w_capped   = (w_d >= CAP8);
    assign w_cnt      = w_capped ? CAP8 : w_d;
    assign w_special  = (w_a_exp == EXP_MAX) || (w_b_exp == EXP_MAX);
    assign w_spec_val = (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && w_eff_sub))
                        ? QNAN : {w_res_sign, EXP_MAX, {MANT_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = (w_special || (w_d == '0)) ? S_ADD : S_ALIGN;
            S_ALIGN: if (r_cnt == 8'd1) w_next = S_ADD;
            S_ADD:   w_next = S_NORM;
            S_NORM: begin
                // Specials pass through NORM untouched so their latency matches the d = 0 path.
                if (r_special || (r_sum == '0) || (r_exp == '0))
                    w_next = S_DONE;
                else if (!r_sum[XW] && r_sum[XW-1])
                    w_next = S_DONE;
            end
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end
    assign diff = r_diff;

    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    r_sign     <= w_res_sign;
                    r_eff_sub  <= w_eff_sub;
                    r_special  <= w_special;
                    r_capped   <= w_capped;
                    r_cnt      <= w_cnt;
                    r_exp      <= w_p_exp;
                    r_p        <= {w_p_sig, 3'b000};
                    r_s        <= {w_s_sig, 3'b000};
                    r_spec_val <= w_spec_val;
                end
            end
            S_ALIGN: begin
                r_cnt <= r_cnt - 8'd1;
                r_s   <= (r_capped && (r_cnt == 8'd1)) ? '0 : XW'(shr_sticky({1'b0, r_s}));
            end
            S_ADD: begin
                r_sum <= r_eff_sub ? ({1'b0, r_p} - {1'b0, r_s}) : ({1'b0, r_p} + {1'b0, r_s});
            end
            S_NORM: begin
                if (!r_special && (r_sum != '0) && (r_exp != '0)) begin
                    if (r_sum[XW]) begin
                        r_sum <= shr_sticky(r_sum);
                        r_exp <= r_exp + 8'd1;
                    end else if (!r_sum[XW-1]) begin
                        r_sum <= r_sum << 1;
                        r_exp <= r_exp - 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Result register only changes on the cycle NORM hands over to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff <= '0;
        end else if (r_state == S_NORM) begin
            if (r_special)
                r_diff <= r_spec_val;
            else if ((r_sum == '0) || (r_exp == '0))
                r_diff <= '0;
            else if (!r_sum[XW] && r_sum[XW-1])
                r_diff <= trunc_pack(r_sign, r_exp, r_sum);
        end
    end

endmodule
